// File: rtl/risc16_prog_loader.sv
// risc16_prog_loader
//   Boot-time program loader sitting in front of the 16-bit RISC core.
//   It accepts a framed stream of words: a length header, then `len`
//   instruction words, then a 16-bit checksum. The instruction words are
//   written into instruction memory. The core is held in reset until a frame
//   has loaded and its checksum matches.
//
// Ports
//   clk, rst_n             system clock, asynchronous active-low reset
//   start                  begin a load (pulse or level)
//   in_data/valid/ready    word stream; a word transfers when valid & ready
//   imem_we/addr/wdata     instruction memory write port (registered)
//   core_rst_n             active-low reset to the core, high only in DONE
//   busy                   high in HDR, LOAD and CHK
//   done / err / err_code  load result; err_code 1 bad length, 2 checksum, 3 timeout
//
// Build option
//   BOOT_TIMEOUT_EN        when defined, a stream that stalls for
//                          TIMEOUT_CYCLES cycles fails with err_code 3.
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | after reset, waiting for start
// HDR   | waiting for the length header word
// LOAD  | receiving instruction words and writing imem
// CHK   | waiting for the checksum word
// DONE  | frame verified, core released from reset
// ERR   | load failed, core held in reset, err_code valid
module risc16_prog_loader #(
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    if (((1 << ADDR_W) < DEPTH) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("risc16_prog_loader: ADDR_W too small for DEPTH or TIMEOUT_CYCLES < 1");
    end

    localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_nx;
    logic [ADDR_W-1:0] len_m1, len_m1_nx;   // length minus one, so DEPTH fits in ADDR_W bits
    logic [DATA_W-1:0] sum, sum_nx;
    logic [1:0]        err_code_nx;
    logic              xfer;
    logic              tmo_hit;

    assign in_ready = (state == HDR) || (state == LOAD) || (state == CHK);
    assign busy     = in_ready;
    assign xfer     = in_valid && in_ready;

`ifdef BOOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts idle cycles since the last transfer or state entry; the edge on
    // which it would reach TIMEOUT_CYCLES is the one that moves to ERR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!busy || xfer || (state_nx != state)) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = busy && !xfer && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        wr_cnt_nx   = wr_cnt;
        len_m1_nx   = len_m1;
        sum_nx      = sum;
        err_code_nx = err_code;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx    = HDR;
                    err_code_nx = 2'd0;
                end
            end
            HDR: begin
                if (xfer) begin
                    if ((in_data == '0) || (in_data > DEPTH_W)) begin
                        state_nx    = ERR;
                        err_code_nx = 2'd1;
                    end else begin
                        len_m1_nx = ADDR_W'(in_data - 1'b1);
                        wr_cnt_nx = '0;
                        sum_nx    = '0;
                        state_nx  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    sum_nx    = sum + in_data;
                    wr_cnt_nx = wr_cnt + 1'b1;
                    if (wr_cnt == len_m1) begin
                        state_nx = CHK;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    if (in_data == sum) begin
                        state_nx    = DONE;
                        err_code_nx = 2'd0;
                    end else begin
                        state_nx    = ERR;
                        err_code_nx = 2'd2;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (tmo_hit) begin
            state_nx    = ERR;
            err_code_nx = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            len_m1     <= '0;
            sum        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state      <= state_nx;
            wr_cnt     <= wr_cnt_nx;
            len_m1     <= len_m1_nx;
            sum        <= sum_nx;
            imem_we    <= (state == LOAD) && xfer;
            if ((state == LOAD) && xfer) begin
                imem_addr  <= wr_cnt;
                imem_wdata <= in_data;
            end
            core_rst_n <= (state_nx == DONE);
            done       <= (state_nx == DONE);
            err        <= (state_nx == ERR);
            err_code   <= err_code_nx;
        end
    end

endmodule
